// File: rtl/mem_port_arbiter_if.sv
// Memory port bundle shared by the requesters and the downstream memory.
//   read/write : request strobes, held until resp
//   be         : byte enables
//   addr/wdata : word address / write data
//   rdata      : read data, valid while resp=1
//   resp       : one-cycle completion pulse
// master = side that issues requests, slave = side that answers them.
interface mem_port_arbiter_if;
   logic        read;
   logic        write;
   logic [3:0]  be;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        resp;

   modport master (output read, write, be, addr, wdata, input rdata, resp);
   modport slave  (input read, write, be, addr, wdata, output rdata, resp);
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-way arbiter for a single memory port, one transaction outstanding at a time.
// Port 0 is the core, port 1 the auxiliary master. Grant is round-robin or fixed
// priority, held until mem resp; a watchdog forces an error response on a stall.
//   clk, rst    : clock, synchronous active-high reset
//   m0, m1      : requester ports (arbiter is the slave side)
//   mem         : downstream memory port (arbiter is the master side)
//   timeout_err : one-cycle pulse when the watchdog fires
module mem_port_arbiter #(
   parameter bit          FIXED_PRIO = 1'b0,
   parameter int unsigned TIMEOUT    = 255,
   parameter logic [31:0] ERR_RDATA  = 32'hDEAD_BEEF
) (
   input  logic                clk,
   input  logic                rst,
   mem_port_arbiter_if.slave   m0,
   mem_port_arbiter_if.slave   m1,
   mem_port_arbiter_if.master  mem,
   output logic                timeout_err
);

   localparam int unsigned WDOG_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [WDOG_W-1:0] WDOG_MAX  = '1;
   localparam logic [WDOG_W-1:0] WDOG_FIRE = (TIMEOUT > 0) ? WDOG_W'(TIMEOUT - 1) : '0;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] BUSY0 = 2'd1;
   localparam logic [1:0] BUSY1 = 2'd2;

   logic [1:0]        state, state_nxt;
   logic              last_grant, last_grant_nxt;
   logic [WDOG_W-1:0] wdog, wdog_nxt;
   logic              req0, req1;
   logic              busy0, busy1;
   logic              fire, done;
   logic [31:0]       rsp_data;

   assign req0 = m0.read | m0.write;
   assign req1 = m1.read | m1.write;

   // Gate with rst so a response arriving in the reset cycle never reaches a port.
   assign busy0 = (state == BUSY0) && !rst;
   assign busy1 = (state == BUSY1) && !rst;

   // A real mem resp in the firing cycle takes precedence over the watchdog.
   assign fire = (TIMEOUT != 0) && (busy0 || busy1) && (wdog == WDOG_FIRE) && !mem.resp;
   assign done = mem.resp | fire;

   assign rsp_data    = mem.resp ? mem.rdata : (fire ? ERR_RDATA : 32'h0);
   assign timeout_err = fire;

   always_comb begin
      state_nxt      = state;
      last_grant_nxt = last_grant;
      wdog_nxt       = wdog;
      case (state)
         IDLE: begin
            wdog_nxt = '0;
            // On a tie, port 0 wins under fixed priority or when port 1 was served last.
            if (req0 && (!req1 || FIXED_PRIO || last_grant)) begin
               state_nxt      = BUSY0;
               last_grant_nxt = 1'b0;
            end else if (req1) begin
               state_nxt      = BUSY1;
               last_grant_nxt = 1'b1;
            end
         end
         BUSY0, BUSY1: begin
            if (done) begin
               state_nxt = IDLE;
            end else if (wdog != WDOG_MAX) begin
               wdog_nxt = wdog + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         wdog       <= '0;
      end else begin
         state      <= state_nxt;
         last_grant <= last_grant_nxt;
         wdog       <= wdog_nxt;
      end
   end

   // Downstream strobes follow the granted requester live; write masks read.
   always_comb begin
      mem.read  = 1'b0;
      mem.write = 1'b0;
      mem.be    = '0;
      mem.addr  = '0;
      mem.wdata = '0;
      m0.resp   = 1'b0;
      m0.rdata  = '0;
      m1.resp   = 1'b0;
      m1.rdata  = '0;
      if (busy0) begin
         mem.read  = m0.read & ~m0.write;
         mem.write = m0.write;
         mem.be    = m0.be;
         mem.addr  = m0.addr;
         mem.wdata = m0.wdata;
         m0.resp   = done;
         m0.rdata  = rsp_data;
      end
      if (busy1) begin
         mem.read  = m1.read & ~m1.write;
         mem.write = m1.write;
         mem.be    = m1.be;
         mem.addr  = m1.addr;
         mem.wdata = m1.wdata;
         m1.resp   = done;
         m1.rdata  = rsp_data;
      end
   end

endmodule
